// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-pipeline constants for the instruction fetch queue.
package if_fetch_queue_pkg;

    localparam int unsigned WORD_WIDTH    = 32;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam int unsigned FETCH_Q_DEPTH = 4;

endpackage : if_fetch_queue_pkg

// File: rtl/if_fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface if_fetch_queue_if #(
    parameter int unsigned DEPTH = if_fetch_queue_pkg::FETCH_Q_DEPTH,
    parameter int unsigned WIDTH = if_fetch_queue_pkg::WORD_WIDTH
);

    logic [WIDTH-1:0]        PC_In;
    logic [WIDTH-1:0]        Instr_In;
    logic                    Valid_In;
    logic                    Flush;
    logic                    Deq;
    logic                    Stall_Out;
    logic                    Valid_Out;
    logic [WIDTH-1:0]        PC_Out;
    logic [WIDTH-1:0]        Instr_Out;
    logic [$clog2(DEPTH):0]  Count;

    modport master (
        output PC_In, Instr_In, Valid_In, Flush, Deq,
        input  Stall_Out, Valid_Out, PC_Out, Instr_Out, Count
    );

    modport slave (
        input  PC_In, Instr_In, Valid_In, Flush, Deq,
        output Stall_Out, Valid_Out, PC_Out, Instr_Out, Count
    );

endinterface : if_fetch_queue_if

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue: one write port, one async read port.
module fetch_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Clear all entries on reset, otherwise write one entry when enabled.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fetch_queue_mem

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: buffers {PC, instr} pairs in FIFO order between
// the PC register and decode, stalls the PC when full, empties on Flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_Q_DEPTH,
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    if_fetch_queue_if.slave  q
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full, empty, push, pop;
    logic [2*WIDTH-1:0] rdata;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Flush wins over both ends; a full queue drops the incoming word (PC is held).
    assign push  = q.Valid_In & ~full & ~q.Flush;
    assign pop   = q.Deq & ~empty & ~q.Flush;

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) u_mem (
        .Clk   (Clk),
        .Rst   (Rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({q.PC_In, q.Instr_In}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Head presentation; stale storage is masked to zero/NOP while empty.
    always_comb begin
        q.Valid_Out = ~empty;
        q.Stall_Out = full;
        q.Count     = count_q;
        q.PC_Out    = '0;
        q.Instr_Out = WIDTH'(NOP_INSTR);
        if (!empty) begin
            q.PC_Out    = rdata[2*WIDTH-1:WIDTH];
            q.Instr_Out = rdata[WIDTH-1:0];
        end
    end

endmodule : if_fetch_queue

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a queue-based scoreboard of expected heads.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic Clk;
    logic Rst;
    int   checks;
    int   passed;
    ent_t sb[$];

    if_fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    if_fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .q   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA0 + (pc >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle: check outputs against the model, clock, then update the model.
    task automatic cycle(input logic rst, input logic vin, input logic [31:0] pc,
                         input logic deq, input logic flush);
        int   n;
        logic push, pop;
        Rst          = rst;
        bus.Valid_In = vin;
        bus.PC_In    = pc;
        bus.Instr_In = instr_of(pc);
        bus.Deq      = deq;
        bus.Flush    = flush;
        n = sb.size();
        chk("count", 32'(bus.Count), 32'(n));
        chk("stall", 32'(bus.Stall_Out), 32'(n == DEPTH));
        chk("valid", 32'(bus.Valid_Out), 32'(n != 0));
        if (n != 0) begin
            chk("head_pc", bus.PC_Out, sb[0].pc);
            chk("head_instr", bus.Instr_Out, sb[0].instr);
        end else begin
            chk("empty_pc", bus.PC_Out, 32'h0);
            chk("empty_instr", bus.Instr_Out, 32'h0);
        end
        @(posedge Clk);
        #1;
        if (!rst || flush) begin
            sb.delete();
        end else begin
            push = vin && (n < DEPTH);
            pop  = deq && (n != 0);
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back('{pc: pc, instr: instr_of(pc)});
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;

        // Reset held two cycles with activity on Valid_In/Deq.
        Rst          = 1'b0;
        bus.Valid_In = 1'b1;
        bus.PC_In    = 32'h0;
        bus.Instr_In = 32'hA0;
        bus.Deq      = 1'b1;
        bus.Flush    = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        sb.delete();

        // Fill to full, then a fifth push that must be dropped.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);

        // Drain with one extra Deq while empty.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Wrap: preload two, then ten push+pop cycles at Count=2, then drain.
        cycle(1'b1, 1'b1, 32'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h04, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'(8 + i * 4), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush at Count=3 with concurrent push and pop, then push 0x40.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'(32'h30 + i * 4), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h3C, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset together with Flush while full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'(32'h50 + i * 4), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h60, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h64, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_if_fetch_queue
